program_dump_tx: RTL and testbench
==================================

PROGRAM_DUMP_TX -- requirements
Module: program_dump_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range 2..4096.
REQ-002 Parameter MEMORY_ADDRESS_WIDTH, default 4: program-memory address width.
REQ-003 Parameter MEMORY_REGISTERS, default 16: number of words dumped; at most 2**MEMORY_ADDRESS_WIDTH.
REQ-004 Parameter WORD_WIDTH, default 8: program-memory word width; legal range 1..8.
REQ-005 clk_i  input  1  single clock; all logic SHALL run on its rising edge.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 start_i  input  1  request to dump memory; level-sampled in IDLE only.
REQ-008 mem_addr_o  output  MEMORY_ADDRESS_WIDTH  program-memory read address.
REQ-009 mem_data_i  input  WORD_WIDTH  memory word; combinational read of mem_addr_o.
REQ-010 tx_o  output  1  UART serial output, 8N1, idle high.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 done_o  output  1  single-cycle pulse after the last stop bit.

Function
REQ-013 States SHALL be IDLE, FETCH, START, DATA, STOP, DONE.
REQ-014 IDLE: tx_o=1, busy_o=0, mem_addr_o=0; if start_i=1 then go to FETCH on the next edge.
REQ-015 FETCH lasts 1 cycle: latch {zero-extension, mem_data_i} into an 8-bit shift register; go to START.
REQ-016 START: tx_o=0 for exactly CLKS_PER_BIT cycles; then go to DATA.
REQ-017 DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles; then go to STOP.
REQ-018 STOP: tx_o=1 for exactly CLKS_PER_BIT cycles.
REQ-019 At the end of STOP, if mem_addr_o = MEMORY_REGISTERS-1, go to DONE; otherwise increment mem_addr_o and go to FETCH.
REQ-020 DONE lasts 1 cycle: done_o=1, tx_o=1; then go to IDLE.
REQ-021 Frame length SHALL be 10*CLKS_PER_BIT cycles with 1 FETCH cycle between frames; total busy time SHALL be MEMORY_REGISTERS*(10*CLKS_PER_BIT+1)+1 cycles.
REQ-022 start_i asserted while busy_o=1 SHALL be ignored; there is no queuing.
REQ-023 start_i held high through DONE SHALL start a new dump from address 0 on the cycle after IDLE is entered.
REQ-024 The baud counter SHALL count 0..CLKS_PER_BIT-1, with width $clog2(CLKS_PER_BIT); the bit counter SHALL count 0..7.
REQ-025 mem_addr_o SHALL be stable from FETCH through the end of STOP for each word.
REQ-026 tx_o SHALL be driven from a register, glitch-free.

Reset
REQ-027 reset_i=1 SHALL force IDLE on the next edge, in every state, including mid-frame.
REQ-028 Reset values SHALL be: tx_o=1, busy_o=0, done_o=0, mem_addr_o=0; baud counter, bit counter and shift register 0.
REQ-029 A frame truncated by reset SHALL NOT resume; the next start_i SHALL begin at address 0.

Structure
REQ-030 The state enum, the frame constants (8 data bits, 1 stop bit) and the default CLKS_PER_BIT SHALL live in the shared CPU package.
REQ-031 The baud tick generator SHALL be one sub-module, baud_tick_gen (clk_i, reset_i, enable_i, tick_o), reusable by the RX loader.

Verification (CLKS_PER_BIT=4, MEMORY_REGISTERS=16, WORD_WIDTH=8)
REQ-032 Memory word 0 = 8'hA5 and start_i pulsed for 1 cycle -> tx_o low for cycles 2-5 after start; data bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop bit high for 4 cycles.
REQ-033 Memory word k = k for all 16 words, then start -> bench UART decoder receives 0x00..0x0F in order; done_o pulses once, 16*41+1=657 cycles after busy_o rises.
REQ-034 WORD_WIDTH=4, word = 4'hF -> received byte 8'h0F.
REQ-035 start_i pulsed again mid-dump at address 5 -> stream is unchanged; exactly one done_o pulse.
REQ-036 reset_i asserted for 1 cycle during DATA of word 3 -> next cycle tx_o=1, busy_o=0, mem_addr_o=0; a new start re-sends from word 0.
REQ-037 start_i held high continuously -> back-to-back dumps, each DONE followed by 1 IDLE cycle, then FETCH of address 0.

Source files
------------

// File: rtl/program_dump_tx_pkg.sv
// Shared CPU package: dump-transmitter state encoding and 8N1 UART frame constants.
package program_dump_tx_pkg;

  localparam int FRAME_DATA_BITS      = 8;
  localparam int FRAME_STOP_BITS      = 1;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: pulses tick_o on the last clock of every bit period while enabled.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int                CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]     LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == LAST_CNT);

  // Held at zero while disabled so every enabled period starts with a full bit time.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    cnt_d = cnt_q;
    if (!enable_i || tick_o) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races between flops.
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/program_dump_tx.sv
// Dumps MEMORY_REGISTERS program-memory words out of a UART 8N1 serial line, one frame per word.
module program_dump_tx
  import program_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT         = DEFAULT_CLKS_PER_BIT,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int MEMORY_REGISTERS     = 16,
  parameter int WORD_WIDTH           = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
  input  logic [WORD_WIDTH-1:0]           mem_data_i,
  output logic                            tx_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR     = MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);
  localparam logic [2:0]                      LAST_DATA_BIT = 3'(FRAME_DATA_BITS - 1);
  localparam logic [2:0]                      LAST_STOP_BIT = 3'(FRAME_STOP_BITS - 1);

  dump_state_e                     state_q;
  logic [7:0]                      shift_q;
  logic [2:0]                      bit_cnt_q;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q;
  logic                            tx_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            baud_en;
  logic                            baud_tick;
  logic [7:0]                      word_ext;

  always_comb begin
    word_ext                   = '0;
    word_ext[WORD_WIDTH-1:0]   = mem_data_i;
  end

  assign baud_en = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enable_i(baud_en),
    .tick_o  (baud_tick)
  );

  // tx_q always carries the level of the state being entered, so the line is a clean flop output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          shift_q   <= word_ext;
          bit_cnt_q <= '0;
          tx_q      <= 1'b0;
          state_q   <= ST_START;
        end
        ST_START: begin
          if (baud_tick) begin
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q == LAST_DATA_BIT) begin
              tx_q      <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= ST_STOP;
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (bit_cnt_q != LAST_STOP_BIT) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (addr_q == LAST_ADDR) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          addr_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr_o = addr_q;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_program_dump_tx.sv
// Directed bench for program_dump_tx: UART decode of dumps, frame timing, mid-dump start, reset abort.
module tb_program_dump_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start4;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       tx, busy, done;
  logic [0:0] addr4;
  logic [3:0] mem_data4;
  logic       tx4, busy4, done4;

  logic [7:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt, done_cnt, done_at;
  int busy4_cnt, done4_cnt;

  always #5 clk = ~clk;

  assign mem_data  = mem[mem_addr];
  assign mem_data4 = addr4[0] ? 4'hA : 4'hF;

  program_dump_tx #(
    .CLKS_PER_BIT(CPB), .MEMORY_ADDRESS_WIDTH(4), .MEMORY_REGISTERS(16), .WORD_WIDTH(8)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mem_addr_o(mem_addr),
    .mem_data_i(mem_data), .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  program_dump_tx #(
    .CLKS_PER_BIT(CPB), .MEMORY_ADDRESS_WIDTH(1), .MEMORY_REGISTERS(2), .WORD_WIDTH(4)
  ) dut4 (
    .clk_i(clk), .reset_i(reset), .start_i(start4), .mem_addr_o(addr4),
    .mem_data_i(mem_data4), .tx_o(tx4), .busy_o(busy4), .done_o(done4)
  );

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_at = busy_cnt;
    end
    if (busy4) busy4_cnt++;
    if (done4) done4_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx4 : tx;
  endfunction

  task automatic clear_counts();
    busy_cnt = 0; done_cnt = 0; done_at = 0; busy4_cnt = 0; done4_cnt = 0;
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start  = 1'b0;
  endtask

  task automatic wait_tx_low(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_of(sel) == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("start_bit_timeout", 64'(ok), 64'd1);
  endtask

  // Samples each bit in the middle of its period, starting from the first low cycle.
  task automatic recv_byte(input bit sel, output logic [7:0] b);
    bit ok;
    b = '0;
    wait_tx_low(sel, ok);
    if (ok) begin
      repeat (CPB + 1) @(negedge clk);
      b[0] = tx_of(sel);
      for (int i = 1; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx_of(sel);
      end
      repeat (CPB) @(negedge clk);
      check("stop_bit", 64'(tx_of(sel)), 64'd1);
    end
  endtask

  task automatic wait_idle(input bit sel);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!(sel ? busy4 : busy)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [40:0] samples, exp_w;
    logic [7:0]  pat;
    bit          ok;

    reset = 1'b1; start = 1'b0; start4 = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = 8'(k);
    mem[0] = 8'hA5;
    clear_counts();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx",    64'(tx),       64'd1);
    check("rst_busy",  64'(busy),     64'd0);
    check("rst_done",  64'(done),     64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    check("rst_tx4",   64'(tx4),      64'd1);

    // Exact waveform of the first frame: FETCH, 4 low, 8 data bits x4, 4 high.
    pat = 8'hA5;
    for (int j = 0; j <= 40; j++) begin
      if (j == 0)       exp_w[j] = 1'b1;
      else if (j <= 4)  exp_w[j] = 1'b0;
      else if (j <= 36) exp_w[j] = pat[(j - 5) / 4];
      else              exp_w[j] = 1'b1;
    end
    pulse_start(1'b0);
    check("busy_after_start", 64'(busy), 64'd1);
    samples[0] = tx;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      samples[j] = tx;
    end
    check("frame_a5_wave", 64'(samples), 64'(exp_w));
    wait_idle(1'b0);

    // Full dump of k -> k, with busy length and a single done pulse on the last busy cycle.
    mem[0] = 8'h00;
    clear_counts();
    pulse_start(1'b0);
    for (int k = 0; k < 16; k++) begin
      recv_byte(1'b0, b);
      check("dump_byte", 64'(b), 64'(k));
    end
    wait_idle(1'b0);
    check("dump_busy_cycles", 64'(busy_cnt), 64'd657);
    check("dump_done_count",  64'(done_cnt), 64'd1);
    check("dump_done_at",     64'(done_at),  64'd657);

    // A second start while busy must not disturb the stream.
    clear_counts();
    pulse_start(1'b0);
    for (int k = 0; k < 16; k++) begin
      recv_byte(1'b0, b);
      check("mid_start_byte", 64'(b), 64'(k));
      if (k == 5) begin
        check("mid_start_addr", 64'(mem_addr), 64'd5);
        pulse_start(1'b0);
      end
    end
    wait_idle(1'b0);
    check("mid_start_busy_cycles", 64'(busy_cnt), 64'd657);
    check("mid_start_done_count",  64'(done_cnt), 64'd1);

    // Reset during DATA of word 3 aborts the dump; restart begins at word 0.
    clear_counts();
    pulse_start(1'b0);
    for (int k = 0; k < 3; k++) recv_byte(1'b0, b);
    wait_tx_low(1'b0, ok);
    repeat (10) @(negedge clk);
    check("abort_addr_before", 64'(mem_addr), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tx",   64'(tx),       64'd1);
    check("abort_busy", 64'(busy),     64'd0);
    check("abort_addr", 64'(mem_addr), 64'd0);
    repeat (50) @(negedge clk);
    check("abort_no_resume", 64'(busy),     64'd0);
    check("abort_no_done",   64'(done_cnt), 64'd0);
    pulse_start(1'b0);
    recv_byte(1'b0, b);
    check("restart_byte0", 64'(b), 64'd0);
    recv_byte(1'b0, b);
    check("restart_byte1", 64'(b), 64'd1);
    wait_idle(1'b0);

    // start held high: DONE, one IDLE cycle, then FETCH of address 0.
    @(negedge clk);
    start = 1'b1;
    wait_done();
    @(negedge clk);
    check("held_idle_busy", 64'(busy), 64'd0);
    check("held_idle_tx",   64'(tx),   64'd1);
    @(negedge clk);
    check("held_refetch_busy", 64'(busy),     64'd1);
    check("held_refetch_addr", 64'(mem_addr), 64'd0);
    start = 1'b0;
    recv_byte(1'b0, b);
    check("held_second_byte0", 64'(b), 64'd0);
    wait_idle(1'b0);

    // Narrow words are zero-extended; two-word dump ends after word 1.
    clear_counts();
    pulse_start(1'b1);
    recv_byte(1'b1, b);
    check("w4_byte0", 64'(b), 64'h0F);
    recv_byte(1'b1, b);
    check("w4_byte1", 64'(b), 64'h0A);
    wait_idle(1'b1);
    check("w4_busy_cycles", 64'(busy4_cnt), 64'd83);
    check("w4_done_count",  64'(done4_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
